// File: rtl/bp_fe_dual_queue.sv
// bp_fe_dual_queue
// Dual-enqueue / dual-present FIFO between FE fetch and the BE scheduler.
// The FE pushes up to two packets per cycle, and the two oldest entries are
// shown to the BE. When the BE asserts ready, every valid slot is popped.
// The FIFO has no bypass path, so a packet written this cycle becomes
// visible on the next cycle.

module bp_fe_dual_queue #(
  parameter int fe_queue_width_lp = 64,
  parameter int els_p             = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clear_i,
  input  logic [fe_queue_width_lp-1:0] enq_pkt1_i,
  input  logic [fe_queue_width_lp-1:0] enq_pkt2_i,
  input  logic                         enq_v1_i,
  input  logic                         enq_v2_i,
  output logic                         enq_ready_o,
  output logic [fe_queue_width_lp-1:0] fe_queue1_o,
  output logic [fe_queue_width_lp-1:0] fe_queue2_o,
  output logic                         fe_queue_v1_o,
  output logic                         fe_queue_v2_o,
  input  logic                         fe_queue_ready_i,
  output logic [$clog2(els_p+1)-1:0]   count_o
);

  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p+1);

  // Packet storage.
  // It is never reset, because the count alone decides which entries are live.
  logic [fe_queue_width_lp-1:0] r_mem [els_p];

  logic [ptr_w_lp-1:0] r_head;
  logic [ptr_w_lp-1:0] r_tail;
  logic [cnt_w_lp-1:0] r_count;

  logic                w_v1;
  logic                w_v2;
  logic                w_enq_ready;
  logic                w_enq_fire;
  logic [1:0]          w_enq_n;
  logic [1:0]          w_deq_n;
  logic [ptr_w_lp-1:0] w_head_p1;
  logic [ptr_w_lp-1:0] w_tail_p1;
  logic [els_p-1:0]    w_wr1;
  logic [els_p-1:0]    w_wr2;

  // Slot valids come straight from the registered occupancy.
  assign w_v1 = (r_count != '0);
  assign w_v2 = (r_count >= cnt_w_lp'(2));

  // Ready requires room for a full pair.
  // It looks only at the registered count and ignores any dequeue in the same cycle.
  assign w_enq_ready = (r_count <= cnt_w_lp'(els_p - 2));
  assign w_enq_fire  = w_enq_ready & enq_v1_i & ~clear_i;
  assign w_enq_n     = w_enq_fire ? (enq_v2_i ? 2'd2 : 2'd1) : 2'd0;

  // The BE takes every valid slot, which is zero, one or two entries.
  // Because v2 implies v1, the pop count is just {v2, v1 & ~v2}.
  assign w_deq_n = (fe_queue_ready_i & ~clear_i) ? {w_v2, w_v1 & ~w_v2} : 2'd0;

  // Depth is a power of two, so pointer arithmetic wraps for free.
  assign w_head_p1 = r_head + ptr_w_lp'(1);
  assign w_tail_p1 = r_tail + ptr_w_lp'(1);

  // Per-entry write selects.
  // pkt1 lands at the tail, and pkt2 lands in the slot just behind it.
  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_wr_sel
      assign w_wr1[gi] = w_enq_fire & (r_tail == ptr_w_lp'(gi));
      assign w_wr2[gi] = w_enq_fire & enq_v2_i & (w_tail_p1 == ptr_w_lp'(gi));
    end
  endgenerate

  // Storage write port.
  // At most one of the two selects is active for any given entry.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < els_p; i++) begin
      if (w_wr1[i]) begin
        r_mem[i] <= enq_pkt1_i;
      end else if (w_wr2[i]) begin
        r_mem[i] <= enq_pkt2_i;
      end
    end
  end

  // Pointer and occupancy update.
  // Reset dominates clear, and clear dominates traffic in the same cycle.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (clear_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + ptr_w_lp'(w_deq_n);
      r_tail  <= r_tail + ptr_w_lp'(w_enq_n);
      r_count <= r_count + cnt_w_lp'(w_enq_n) - cnt_w_lp'(w_deq_n);
    end
  end

  // Flag protocol misuse by the FE.
  // These are warnings only, because the hardware simply drops the request.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(enq_v2_i && !enq_v1_i))
        else $warning("enq_v2_i without enq_v1_i ignored");
      assert (!(enq_v1_i && !w_enq_ready && !clear_i))
        else $warning("enqueue while not ready dropped");
    end
  end

  // Present the two oldest entries.
  // Each data slot is zeroed whenever it is not valid.
  assign fe_queue_v1_o = w_v1;
  assign fe_queue_v2_o = w_v2;
  assign fe_queue1_o   = w_v1 ? r_mem[r_head]    : '0;
  assign fe_queue2_o   = w_v2 ? r_mem[w_head_p1] : '0;
  assign enq_ready_o   = w_enq_ready;
  assign count_o       = r_count;

endmodule

// File: tb/tb_bp_fe_dual_queue.sv
// Directed bench for bp_fe_dual_queue.
// It uses 16-bit packets and a depth of 8.
module tb_bp_fe_dual_queue;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clr = 1'b0;
  logic [W-1:0] pkt1 = '0;
  logic [W-1:0] pkt2 = '0;
  logic         ev1 = 1'b0;
  logic         ev2 = 1'b0;
  logic         eready;
  logic [W-1:0] q1;
  logic [W-1:0] q2;
  logic         qv1;
  logic         qv2;
  logic         bready = 1'b0;
  logic [3:0]   cnt;

  int n_vec  = 0;
  int n_miss = 0;

  bp_fe_dual_queue #(.fe_queue_width_lp(W), .els_p(8)) dut (
    .clk_i            (clk),
    .reset_i          (rst),
    .clear_i          (clr),
    .enq_pkt1_i       (pkt1),
    .enq_pkt2_i       (pkt2),
    .enq_v1_i         (ev1),
    .enq_v2_i         (ev2),
    .enq_ready_o      (eready),
    .fe_queue1_o      (q1),
    .fe_queue2_o      (q2),
    .fe_queue_v1_o    (qv1),
    .fe_queue_v2_o    (qv2),
    .fe_queue_ready_i (bready),
    .count_o          (cnt)
  );

  always #5 clk = ~clk;

  // One comparison.
  // A mismatch prints one line.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full snapshot of the presented state.
  task automatic chk_q(input string tag, input logic v1, input logic v2,
                       input logic [W-1:0] e1, input logic [W-1:0] e2,
                       input int c, input logic rdy);
    chk({tag, ".v1"},  32'(qv1), 32'(v1));
    chk({tag, ".v2"},  32'(qv2), 32'(v2));
    chk({tag, ".q1"},  32'(q1),  32'(e1));
    chk({tag, ".q2"},  32'(q2),  32'(e2));
    chk({tag, ".cnt"}, 32'(cnt), 32'(c));
    chk({tag, ".rdy"}, 32'(eready), 32'(rdy));
    $display("vec %s: v1=%0b v2=%0b q1=%0h q2=%0h cnt=%0d rdy=%0b", tag, qv1, qv2, q1, q2, cnt, eready);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_enq(input logic v1, input logic v2, input logic [W-1:0] a, input logic [W-1:0] b);
    ev1  = v1;
    ev2  = v2;
    pkt1 = a;
    pkt2 = b;
  endtask

  initial begin
    // Reset state, observed while reset is still held.
    #1;
    chk_q("reset", 0, 0, 0, 0, 0, 1);
    tick();
    rst = 1'b0;

    // 1: dual enqueue into an empty queue.
    set_enq(1, 1, 16'h00A1, 16'h00B2);
    tick();
    set_enq(0, 0, 0, 0);
    chk_q("t1_dual", 1, 1, 16'h00A1, 16'h00B2, 2, 1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk_q("t1_drain", 0, 0, 0, 0, 0, 1);

    // 2: single enqueue while the BE is already ready.
    bready = 1'b1;
    set_enq(1, 0, 16'h00A3, 16'h0000);
    tick();
    set_enq(0, 0, 0, 0);
    chk_q("t2_c1", 1, 0, 16'h00A3, 0, 1, 1);
    tick();
    bready = 1'b0;
    chk_q("t2_c2", 0, 0, 0, 0, 0, 1);

    // 3: fill to 8 with four pairs, then show a dropped enqueue.
    for (int k = 0; k < 4; k++) begin
      set_enq(1, 1, W'(16'h0030 + 2 * k), W'(16'h0031 + 2 * k));
      tick();
      chk({"t3_fill_cnt", string'(8'h30 + 8'(k))}, 32'(cnt), 32'(2 * k + 2));
    end
    chk("t3_rdy_at8", 32'(eready), 32'(0));
    set_enq(1, 1, 16'hDEAD, 16'hBEEF);
    tick();
    set_enq(0, 0, 0, 0);
    chk_q("t3_drop", 1, 1, 16'h0030, 16'h0031, 8, 0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk_q("t3_pop6", 1, 1, 16'h0032, 16'h0033, 6, 1);
    set_enq(1, 0, 16'h0038, 16'h0000);
    tick();
    set_enq(0, 0, 0, 0);
    chk_q("t3_at7", 1, 1, 16'h0032, 16'h0033, 7, 0);
    bready = 1'b1;
    tick();
    chk_q("t3_d5", 1, 1, 16'h0034, 16'h0035, 5, 1);
    tick();
    chk_q("t3_d3", 1, 1, 16'h0036, 16'h0037, 3, 1);
    tick();
    chk_q("t3_d1", 1, 0, 16'h0038, 0, 1, 1);
    tick();
    bready = 1'b0;
    chk_q("t3_d0", 0, 0, 0, 0, 0, 1);

    // 4: stream pairs with the BE ready every cycle.
    // The head starts at 4 and wraps past 7.
    bready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_enq(1, 1, W'(16'h0040 + 2 * k), W'(16'h0041 + 2 * k));
      tick();
      chk_q({"t4_wrap", string'(8'h30 + 8'(k))}, 1, 1,
            W'(16'h0040 + 2 * k), W'(16'h0041 + 2 * k), 2, 1);
    end
    set_enq(0, 0, 0, 0);
    tick();
    bready = 1'b0;
    chk_q("t4_end", 0, 0, 0, 0, 0, 1);

    // 5: clear overrides an enqueue and a dequeue in the same cycle.
    set_enq(1, 1, 16'h0050, 16'h0051);
    tick();
    set_enq(1, 1, 16'h0052, 16'h0053);
    tick();
    set_enq(1, 0, 16'h0054, 16'h0000);
    tick();
    chk_q("t5_pre", 1, 1, 16'h0050, 16'h0051, 5, 1);
    clr    = 1'b1;
    bready = 1'b1;
    set_enq(1, 1, 16'h0055, 16'h0056);
    tick();
    clr    = 1'b0;
    bready = 1'b0;
    set_enq(0, 0, 0, 0);
    chk_q("t5_clear", 0, 0, 0, 0, 0, 1);
    set_enq(1, 0, 16'h0060, 16'h0000);
    tick();
    set_enq(0, 0, 0, 0);
    chk_q("t5_post", 1, 0, 16'h0060, 0, 1, 1);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // 6: asynchronous reset asserted between clock edges.
    set_enq(1, 1, 16'h0070, 16'h0071);
    tick();
    set_enq(1, 0, 16'h0072, 16'h0000);
    tick();
    set_enq(0, 0, 0, 0);
    chk_q("t6_pre", 1, 1, 16'h0070, 16'h0071, 3, 1);
    #2;
    rst = 1'b1;
    #1;
    chk_q("t6_async", 0, 0, 0, 0, 0, 1);
    tick();
    rst = 1'b0;
    set_enq(1, 1, 16'h0080, 16'h0081);
    tick();
    set_enq(0, 0, 0, 0);
    chk_q("t6_after", 1, 1, 16'h0080, 16'h0081, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
